// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the serial pattern transmitter.
//   ST_IDLE/ST_SHIFT/ST_GAP/ST_DONE : FSM state encodings
//   seq_state_e                     : FSM state type built on those encodings
//   SEQ_PAT_100                     : default 3-bit pattern recognised by the detector
package seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_GAP   = ST_GAP,
    S_DONE  = ST_DONE
  } seq_state_e;

  localparam logic [2:0] SEQ_PAT_100 = 3'b100;

endpackage

// File: rtl/seq_shift_reg.sv
// seq_shift_reg: holds the captured pattern and walks a bit index from len_m1
// down to 0. On the step after bit 0 the index wraps to the captured length so
// a repeat starts without reloading from the (possibly changed) inputs.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears pattern and index)
//   load      : capture pat_data and len_m1, point at bit len_m1
//   shift     : advance to the next lower bit (wrap after bit 0)
//   pat_data  : pattern to capture
//   len_m1    : pattern length minus 1
//   cur_bit   : pattern bit at the current index
//   last      : current index is bit 0
module seq_shift_reg
  import seq_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] pat_data,
  input  logic [LEN_W-1:0] len_m1,
  output logic             cur_bit,
  output logic             last
);

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= '0;
      len_q <= '0;
      idx_q <= '0;
    end else if (load) begin
      pat_q <= pat_data;
      len_q <= len_m1;
      idx_q <= len_m1;
    end else if (shift) begin
      idx_q <= (idx_q == '0) ? len_q : idx_q - 1'b1;
    end
  end

  assign cur_bit = pat_q[idx_q];
  assign last    = (idx_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial bit-pattern transmitter feeding the sequence detector.
// Sends a captured 1..PAT_W-bit pattern MSB-first, one bit per enabled cycle,
// rep+1 times, then pulses done for one enabled cycle.
// Optional feature: define SEQTX_GAP_EN to insert GAP_CYC idle cycles between
// repeats (busy stays high, x_valid low) so the detector can return to S0.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (any state -> IDLE)
//   ena       : cycle qualifier; all state holds while low
//   start     : transfer request, honoured only in IDLE
//   pat_data  : pattern, bit len_m1 sent first, bit 0 last
//   len_m1    : pattern length minus 1
//   rep       : number of extra repeats
//   x_out     : serial bit (0 when x_valid is low)
//   x_valid   : x_out carries a pattern bit
//   busy      : transfer in progress
//   done      : one-cycle completion pulse
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int PAT_W   = 8,
  parameter int LEN_W   = 3,
  parameter int CNT_W   = 4,
  parameter int GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic [PAT_W-1:0] pat_data,
  input  logic [LEN_W-1:0] len_m1,
  input  logic [CNT_W-1:0] rep,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] rep_q;
  logic             load, shift, rep_dec;
  logic             cur_bit, last;

`ifdef SEQTX_GAP_EN
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  logic [GAP_W-1:0] gap_q;
  logic             gap_load;
`endif

  seq_shift_reg #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .pat_data (pat_data),
    .len_m1   (len_m1),
    .cur_bit  (cur_bit),
    .last     (last)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    rep_dec = 1'b0;
`ifdef SEQTX_GAP_EN
    gap_load = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (ena && start) begin
          load    = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (ena) begin
          // The shift register wraps its index on its own after bit 0, so a
          // repeat needs no reload here; only the counter and state change.
          shift = 1'b1;
          if (last) begin
            if (rep_q != '0) begin
              rep_dec = 1'b1;
`ifdef SEQTX_GAP_EN
              gap_load = 1'b1;
              state_d  = S_GAP;
`endif
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
`ifdef SEQTX_GAP_EN
      S_GAP: begin
        if (ena && gap_q == '0) state_d = S_SHIFT;
      end
`endif
      S_DONE: begin
        if (ena) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load)         rep_q <= rep;
      else if (rep_dec) rep_q <= rep_q - 1'b1;
    end
  end

`ifdef SEQTX_GAP_EN
  // Counts down from GAP_CYC-1; the gap ends on the enabled edge that sees 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q <= '0;
    end else if (gap_load) begin
      gap_q <= GAP_W'(GAP_CYC - 1);
    end else if (state_q == S_GAP && ena && gap_q != '0) begin
      gap_q <= gap_q - 1'b1;
    end
  end
`endif

  assign x_valid = (state_q == S_SHIFT);
  assign x_out   = x_valid & cur_bit;
  assign busy    = (state_q == S_SHIFT) || (state_q == S_GAP);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: randomized bench for seq_pattern_tx against a stream model.
// The model expands each accepted request into the full list of per-cycle
// outputs (bits, optional gaps, done) and pops one entry per enabled edge.
module tb_seq_pattern_tx;
  import seq_pkg::*;

  localparam int PAT_W   = 8;
  localparam int LEN_W   = 3;
  localparam int CNT_W   = 4;
  localparam int GAP_CYC = 2;

  logic             clk = 1'b0;
  logic             rst, ena, start;
  logic [PAT_W-1:0] pat_data;
  logic [LEN_W-1:0] len_m1;
  logic [CNT_W-1:0] rep;
  logic             x_out, x_valid, busy, done;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic xv;
    logic xo;
    logic bsy;
    logic dn;
  } obs_t;

  obs_t q[$];
  obs_t cur = '0;

  seq_pattern_tx #(
    .PAT_W   (PAT_W),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .start    (start),
    .pat_data (pat_data),
    .len_m1   (len_m1),
    .rep      (rep),
    .x_out    (x_out),
    .x_valid  (x_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t dut_obs();
    return {x_valid, x_out, busy, done};
  endfunction

  task automatic build_q();
    for (int r = 0; r <= int'(rep); r++) begin
      for (int i = int'(len_m1); i >= 0; i--)
        q.push_back(obs_t'({1'b1, pat_data[i], 1'b1, 1'b0}));
`ifdef SEQTX_GAP_EN
      if (r < int'(rep))
        for (int g = 0; g < GAP_CYC; g++) q.push_back(obs_t'(4'b0010));
`endif
    end
    q.push_back(obs_t'(4'b0001));
  endtask

  // One clock: advance the model on the edge, then compare away from the edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      q.delete();
      cur = '0;
    end else if (ena) begin
      if (q.size() > 0)  cur = q.pop_front();
      else if (cur.dn)   cur = '0;
      else if (start) begin
        build_q();
        cur = q.pop_front();
      end
    end
    #1;
    check_val("outs", 32'(dut_obs()), 32'(cur));
  endtask

  task automatic send(input logic [PAT_W-1:0] p, input int len, input int rp,
                      input int ena_pct, input int stall_at, input int repulse_at,
                      output int vcnt, output int bcnt, output logic [31:0] bits);
    bit seen_done;
    pat_data = p;
    len_m1   = LEN_W'(len);
    rep      = CNT_W'(rp);
    ena      = 1'b1;
    start    = 1'b1;
    cycle();
    start = 1'b0;
    vcnt  = x_valid ? 1 : 0;
    bcnt  = busy ? 1 : 0;
    bits  = {31'd0, x_out};
    seen_done = 1'b0;
    // Captured values must be immune to later input changes.
    pat_data = PAT_W'($urandom);
    len_m1   = LEN_W'($urandom);
    rep      = CNT_W'($urandom);
    for (int k = 1; k < 1500 && !seen_done; k++) begin
      ena   = (k >= stall_at && k < stall_at + 3) ? 1'b0 : ($urandom_range(0, 99) < ena_pct);
      start = (k == repulse_at);
      cycle();
      if (ena) begin
        if (x_valid) begin
          vcnt++;
          bits = {bits[30:0], x_out};
        end
        if (busy) bcnt++;
        if (done) seen_done = 1'b1;
      end
    end
    start = 1'b0;
    if (!seen_done) check_val("timeout", 32'd0, 32'd1);
    ena = 1'b1;
    cycle();
  endtask

  function automatic int exp_busy(input int len, input int rp);
`ifdef SEQTX_GAP_EN
    return (len + 1) * (rp + 1) + GAP_CYC * rp;
`else
    return (len + 1) * (rp + 1);
`endif
  endfunction

  initial begin
    int          vc, bc;
    logic [31:0] bits;
    int          len, rp;

    rst = 1'b1; ena = 1'b0; start = 1'b0;
    pat_data = '0; len_m1 = '0; rep = '0;
    cycle();
    cycle();
    check_val("reset_state", 32'(dut_obs()), 32'd0);
    rst = 1'b0;
    cycle();

    // Reset in the middle of a transfer.
    ena = 1'b1; pat_data = 8'hC3; len_m1 = 3'd7; rep = 4'd2; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (4) cycle();
    rst = 1'b1;
    cycle();
    cycle();
    check_val("rst_mid_idle", 32'(dut_obs()), 32'd0);
    rst = 1'b0;
    cycle();

    // 3-bit "100" pattern, single send.
    send(8'h04, 2, 0, 100, 10000, 0, vc, bc, bits);
    check_val("p100_bits", bits & 32'h7, 32'(SEQ_PAT_100));
    check_val("p100_vcnt", 32'(vc), 32'd3);

    // A5 sent twice.
    send(8'hA5, 7, 1, 100, 10000, 0, vc, bc, bits);
    check_val("a5_bits", bits & 32'hFFFF, 32'hA5A5);
    check_val("a5_vcnt", 32'(vc), 32'd16);
    check_val("a5_busy", 32'(bc), 32'(exp_busy(7, 1)));

    // Stall for 3 cycles mid-pattern.
    send(8'h5A, 7, 0, 100, 3, 0, vc, bc, bits);
    check_val("stall_bits", bits & 32'hFF, 32'h5A);
    check_val("stall_vcnt", 32'(vc), 32'd8);

    // Re-pulsed start while busy is ignored.
    send(8'h0B, 3, 1, 100, 10000, 4, vc, bc, bits);
    check_val("repulse_vcnt", 32'(vc), 32'd8);
    check_val("repulse_bits", bits & 32'hFF, 32'hBB);

    // Boundary: 1-bit pattern, maximum repeat count.
    send(8'h01, 0, 15, 100, 10000, 0, vc, bc, bits);
    check_val("min_len_vcnt", 32'(vc), 32'd16);
    check_val("min_len_bits", bits & 32'hFFFF, 32'hFFFF);

    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(0, 7);
      rp  = (n % 8 == 7) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      send(PAT_W'($urandom), len, rp, $urandom_range(60, 100),
           $urandom_range(1, 12), $urandom_range(1, 10), vc, bc, bits);
      check_val("rnd_vcnt", 32'(vc), 32'((len + 1) * (rp + 1)));
      check_val("rnd_busy", 32'(bc), 32'(exp_busy(len, rp)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
